// File: rtl/shift_rotate_unit_pkg.sv
// -----------------------------------------------------------------------------
// shift_rotate_unit_pkg
//   Shared definitions for the multi-cycle shift/rotate unit: operation codes,
//   FSM state encodings and a helper that classifies an op code as legal.
//   Imported by the unit, its shift step, and anything that drives or checks it.
// -----------------------------------------------------------------------------
package shift_rotate_unit_pkg;

   typedef enum logic [2:0] {
      OP_SHR  = 3'd0,
      OP_SHRA = 3'd1,
      OP_SHL  = 3'd2,
      OP_ROR  = 3'd3,
      OP_ROL  = 3'd4
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_e;

   // Codes 5..7 are reserved and reported through the illegal flag.
   function automatic logic op_is_legal(input logic [2:0] op);
      return (op <= 3'd4);
   endfunction

endpackage

// File: rtl/shift_rotate_unit_if.sv
// -----------------------------------------------------------------------------
// shift_rotate_unit_if
//   Request/response bundle between the control sequencer (master) and the
//   shift/rotate unit (slave).
//   Handshake: the master raises start with op/operand/amount; the request is
//   taken on the first rising edge where the unit is idle (busy=0). While busy=1
//   start is ignored. done pulses for one cycle with result/illegal valid; result
//   is then held until the next request is taken.
//   Signals: start, op[2:0], operand[W], amount[W]  (master -> slave)
//            result[W], busy, done, illegal          (slave -> master)
// -----------------------------------------------------------------------------
interface shift_rotate_unit_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic [2:0]       op;
   logic [WIDTH-1:0] operand;
   logic [WIDTH-1:0] amount;
   logic [WIDTH-1:0] result;
   logic             busy;
   logic             done;
   logic             illegal;

   modport master (
      output start, op, operand, amount,
      input  result, busy, done, illegal
   );

   modport slave (
      input  start, op, operand, amount,
      output result, busy, done, illegal
   );
endinterface

// File: rtl/shift_rotate_unit_shift_step.sv
// -----------------------------------------------------------------------------
// shift_step
//   Combinational single step of the shift/rotate unit: moves value_i by k_i
//   positions (0..STEP) according to op_i. Unknown ops pass the value through.
//   Ports: value_i[WIDTH], op_i[3], k_i[KW] in; value_o[WIDTH] out.
// -----------------------------------------------------------------------------
module shift_step
   import shift_rotate_unit_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int STEP  = 1,
   parameter int KW    = $clog2(STEP + 1)
) (
   input  logic [WIDTH-1:0] value_i,
   input  logic [2:0]       op_i,
   input  logic [KW-1:0]    k_i,
   output logic [WIDTH-1:0] value_o
);

   logic [2*WIDTH-1:0] dbl;
   logic [2*WIDTH-1:0] rot;

   always_comb begin
      // Rotations are taken from a doubled copy so no bits are lost.
      dbl     = {value_i, value_i};
      rot     = '0;
      value_o = value_i;
      case (op_i)
         OP_SHR:  value_o = value_i >> k_i;
         OP_SHRA: value_o = $unsigned($signed(value_i) >>> k_i);
         OP_SHL:  value_o = value_i << k_i;
         OP_ROR: begin
            rot     = dbl >> k_i;
            value_o = rot[WIDTH-1:0];
         end
         OP_ROL: begin
            rot     = dbl << k_i;
            value_o = rot[2*WIDTH-1:WIDTH];
         end
         default: value_o = value_i;
      endcase
   end

endmodule

// File: rtl/shift_rotate_unit.sv
// -----------------------------------------------------------------------------
// shift_rotate_unit
//   Multi-cycle SHR/SHRA/SHL/ROR/ROL execution unit. The operand is captured on
//   accept and moved by up to STEP bits per clock until the requested amount
//   (amount mod WIDTH) is consumed; done then pulses for one cycle.
//   Ports: clock, clear (async active-low reset),
//          bus (shift_rotate_unit_if.slave), dbg_state (current FSM state).
// -----------------------------------------------------------------------------
module shift_rotate_unit
   import shift_rotate_unit_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int STEP  = 1
) (
   input  logic                clock,
   input  logic                clear,
   shift_rotate_unit_if.slave  bus,
   output state_e              dbg_state
);

   localparam int AMT_W = $clog2(WIDTH);
   localparam int KW    = $clog2(STEP + 1);
   localparam logic [AMT_W-1:0] STEP_A = AMT_W'(STEP);

   state_e             state_q, state_d;
   logic [2:0]         op_q, op_d;
   logic [AMT_W-1:0]   rem_q, rem_d;
   logic [WIDTH-1:0]   result_q, result_d;

   logic [AMT_W-1:0]   amt_n;
   logic [AMT_W-1:0]   k_full;
   logic [WIDTH-1:0]   stepped;
   logic               unused_amount_bits;

   // Only the low AMT_W bits of the amount matter (shift is taken mod WIDTH).
   assign amt_n              = bus.amount[AMT_W-1:0];
   assign unused_amount_bits = ^bus.amount[WIDTH-1:AMT_W];

   // The last step may be shorter than STEP.
   assign k_full = (rem_q < STEP_A) ? rem_q : STEP_A;

   shift_step #(
      .WIDTH (WIDTH),
      .STEP  (STEP),
      .KW    (KW)
   ) u_step (
      .value_i (result_q),
      .op_i    (op_q),
      .k_i     (k_full[KW-1:0]),
      .value_o (stepped)
   );

   // State register
   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Datapath registers
   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         op_q     <= 3'd0;
         rem_q    <= '0;
         result_q <= '0;
      end else begin
         op_q     <= op_d;
         rem_q    <= rem_d;
         result_q <= result_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.start) begin
               if (!op_is_legal(bus.op) || (amt_n == '0)) begin
                  state_d = ST_DONE;
               end else begin
                  state_d = ST_SHIFT;
               end
            end
         end
         ST_SHIFT: begin
            // This edge consumes the final chunk of the amount.
            if (rem_q <= STEP_A) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // Datapath next values
   always_comb begin
      op_d     = op_q;
      rem_d    = rem_q;
      result_d = result_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.start) begin
               op_d     = bus.op;
               result_d = bus.operand;
               rem_d    = op_is_legal(bus.op) ? amt_n : '0;
            end
         end
         ST_SHIFT: begin
            result_d = stepped;
            rem_d    = rem_q - k_full;
         end
         default: ;
      endcase
   end

   // Outputs
   always_comb begin
      bus.busy    = (state_q != ST_IDLE);
      bus.done    = (state_q == ST_DONE);
      bus.illegal = (state_q == ST_DONE) && !op_is_legal(op_q);
      bus.result  = result_q;
      dbg_state   = state_q;
   end

endmodule

// File: tb/tb_shift_rotate_unit.sv
// -----------------------------------------------------------------------------
// tb_shift_rotate_unit
//   Drives two units (STEP=1 and STEP=4) with the same request stream and checks
//   results, illegal flags and latency against an arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_shift_rotate_unit;
   import shift_rotate_unit_pkg::*;

   localparam int W = 32;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic clear;
   always #5 clk = ~clk;

   // ---------------- shared stimulus ----------------
   logic         start;
   logic [2:0]   op;
   logic [W-1:0] operand;
   logic [W-1:0] amount;

   shift_rotate_unit_if #(.WIDTH(W)) bus1 ();
   shift_rotate_unit_if #(.WIDTH(W)) bus4 ();
   state_e st1, st4;

   assign bus1.start   = start;
   assign bus1.op      = op;
   assign bus1.operand = operand;
   assign bus1.amount  = amount;
   assign bus4.start   = start;
   assign bus4.op      = op;
   assign bus4.operand = operand;
   assign bus4.amount  = amount;

   shift_rotate_unit #(.WIDTH(W), .STEP(1)) dut1 (
      .clock     (clk),
      .clear     (clear),
      .bus       (bus1),
      .dbg_state (st1)
   );

   shift_rotate_unit #(.WIDTH(W), .STEP(4)) dut4 (
      .clock     (clk),
      .clear     (clear),
      .bus       (bus4),
      .dbg_state (st4)
   );

   int total = 0;
   int bad   = 0;
   logic [W-1:0] exp_q[$];

   // ---------------- reference model ----------------
   function automatic logic [W-1:0] ref_shift(input logic [2:0] o, input logic [W-1:0] v,
                                              input int n);
      logic [W-1:0] r;
      r = v;
      case (o)
         3'd0: r = v >> n;
         3'd1: for (int i = 0; i < n; i++) r = {r[W-1], r[W-1:1]};
         3'd2: r = v << n;
         3'd3: r = (n == 0) ? v : ((v >> n) | (v << (W - n)));
         3'd4: r = (n == 0) ? v : ((v << n) | (v >> (W - n)));
         default: r = v;
      endcase
      return r;
   endfunction

   function automatic int ref_lat(input logic [2:0] o, input int n, input int step);
      if (o > 3'd4 || n == 0) return 1;
      return (n + step - 1) / step + 1;
   endfunction

   // ---------------- driver ----------------
   // Issues one request and waits for done from both units. lat counts edges
   // from the accepting edge (edge 1) to the edge after which done is high.
   task automatic do_op(input logic [2:0] o, input logic [W-1:0] v, input logic [W-1:0] a,
                        output logic [W-1:0] r1, output logic i1, output int l1, output int b1,
                        output logic [W-1:0] r4, output logic i4, output int l4);
      int e;
      @(negedge clk);
      start = 1'b1; op = o; operand = v; amount = a;
      e = 0; l1 = 0; l4 = 0; b1 = 0;
      r1 = '0; r4 = '0; i1 = 1'b0; i4 = 1'b0;
      while (e < 200 && (l1 == 0 || l4 == 0)) begin
         @(posedge clk);
         e++;
         @(negedge clk);
         if (e == 1) begin
            // Inputs may change freely once taken.
            start = 1'b0; operand = $urandom; amount = $urandom; op = 3'($urandom_range(0, 7));
         end
         if (l1 == 0) begin
            if (bus1.done) begin
               l1 = e; r1 = bus1.result; i1 = bus1.illegal;
            end else if (bus1.busy) begin
               b1++;
            end
         end
         if (l4 == 0 && bus4.done) begin
            l4 = e; r4 = bus4.result; i4 = bus4.illegal;
         end
      end
      if (l1 == 0 || l4 == 0) begin
         total++; bad++;
         $display("FAIL do_op_timeout: got l1=%0d l4=%0d, want both done within 200 edges", l1, l4);
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      clear = 1'b0; start = 1'b0; op = 3'd0; operand = '0; amount = '0;
      repeat (3) @(negedge clk);
      total++;
      if (bus1.result !== 32'h0) begin bad++; $display("FAIL reset_result: got %h want 0", bus1.result); end
      total++;
      if ({bus1.busy, bus1.done, bus1.illegal} !== 3'b000) begin
         bad++; $display("FAIL reset_flags: got %b want 000", {bus1.busy, bus1.done, bus1.illegal});
      end
      total++;
      if (st1 !== ST_IDLE || st4 !== ST_IDLE) begin
         bad++; $display("FAIL reset_state: got %0d/%0d want 0/0", st1, st4);
      end
      total++;
      if (bus4.result !== 32'h0 || bus4.busy !== 1'b0 || bus4.done !== 1'b0) begin
         bad++; $display("FAIL reset_dut4: got r=%h b=%b d=%b want 0", bus4.result, bus4.busy, bus4.done);
      end
      clear = 1'b1;
   endtask

   typedef struct {
      logic [2:0]   o;
      logic [W-1:0] v;
      logic [W-1:0] a;
      logic [W-1:0] x;
      logic         ill;
      int           lat1;
      int           lat4;
   } vec_t;

   task automatic test_directed();
      vec_t vecs[8];
      logic [W-1:0] r1, r4;
      logic i1, i4;
      int l1, b1, l4;
      vecs[0] = '{3'd0, 32'hF000_0002, 32'd2,  32'h3C00_0000, 1'b0, 3, 2};
      vecs[1] = '{3'd1, 32'hF000_0002, 32'd2,  32'hFC00_0000, 1'b0, 3, 2};
      vecs[2] = '{3'd3, 32'hF000_0002, 32'd2,  32'hBC00_0000, 1'b0, 3, 2};
      vecs[3] = '{3'd2, 32'hF000_0002, 32'd2,  32'hC000_0008, 1'b0, 3, 2};
      vecs[4] = '{3'd4, 32'hF000_0002, 32'd4,  32'h0000_002F, 1'b0, 5, 2};
      vecs[5] = '{3'd0, 32'h1234_5678, 32'd0,  32'h1234_5678, 1'b0, 1, 1};
      vecs[6] = '{3'd0, 32'h8000_0000, 32'd33, 32'h4000_0000, 1'b0, 2, 2};
      vecs[7] = '{3'd6, 32'hDEAD_BEEF, 32'd5,  32'hDEAD_BEEF, 1'b1, 1, 1};
      for (int i = 0; i < 8; i++) begin
         do_op(vecs[i].o, vecs[i].v, vecs[i].a, r1, i1, l1, b1, r4, i4, l4);
         total++;
         if (r1 !== vecs[i].x || r4 !== vecs[i].x) begin
            bad++; $display("FAIL dir_result[%0d]: got %h/%h want %h", i, r1, r4, vecs[i].x);
         end
         total++;
         if (i1 !== vecs[i].ill || i4 !== vecs[i].ill) begin
            bad++; $display("FAIL dir_illegal[%0d]: got %b/%b want %b", i, i1, i4, vecs[i].ill);
         end
         total++;
         if (l1 !== vecs[i].lat1 || l4 !== vecs[i].lat4) begin
            bad++; $display("FAIL dir_latency[%0d]: got %0d/%0d want %0d/%0d", i, l1, l4,
                            vecs[i].lat1, vecs[i].lat4);
         end
         total++;
         if (b1 !== vecs[i].lat1 - 1) begin
            bad++; $display("FAIL dir_busy_cycles[%0d]: got %0d want %0d", i, b1, vecs[i].lat1 - 1);
         end
         // One cycle after done: idle, flags low, result held.
         @(negedge clk);
         total++;
         if (bus1.done !== 1'b0 || bus1.busy !== 1'b0 || bus1.illegal !== 1'b0 ||
             bus1.result !== vecs[i].x) begin
            bad++; $display("FAIL dir_after_done[%0d]: got d=%b b=%b i=%b r=%h want 0 0 0 %h", i,
                            bus1.done, bus1.busy, bus1.illegal, bus1.result, vecs[i].x);
         end
      end
   endtask

   task automatic test_random();
      logic [W-1:0] r1, r4, v, a, x;
      logic [2:0] o;
      logic i1, i4;
      int l1, b1, l4, n;
      for (int i = 0; i < 40; i++) begin
         o = 3'($urandom_range(0, 7));
         v = $urandom;
         a = $urandom;
         n = int'(a % W);
         exp_q.push_back(ref_shift(o, v, n));
         do_op(o, v, a, r1, i1, l1, b1, r4, i4, l4);
         x = exp_q.pop_front();
         total++;
         if (r1 !== x || r4 !== x) begin
            bad++; $display("FAIL rnd_result[%0d]: op=%0d v=%h n=%0d got %h/%h want %h", i, o, v, n,
                            r1, r4, x);
         end
         total++;
         if (i1 !== (o > 3'd4) || i4 !== (o > 3'd4)) begin
            bad++; $display("FAIL rnd_illegal[%0d]: got %b/%b want %b", i, i1, i4, (o > 3'd4));
         end
         total++;
         if (l1 !== ref_lat(o, n, 1) || l4 !== ref_lat(o, n, 4)) begin
            bad++; $display("FAIL rnd_latency[%0d]: got %0d/%0d want %0d/%0d", i, l1, l4,
                            ref_lat(o, n, 1), ref_lat(o, n, 4));
         end
      end
   endtask

   // Extra starts during SHIFT and on the done cycle must be dropped.
   task automatic test_ignore_start();
      logic [W-1:0] r1, r4;
      logic i1, i4;
      int l1, b1, l4, e, w;
      @(negedge clk);
      start = 1'b1; op = 3'd0; operand = 32'hF000_0002; amount = 32'd4;
      for (e = 1; e <= 6; e++) begin
         @(posedge clk);
         @(negedge clk);
         case (e)
            1: begin start = 1'b0; operand = $urandom; amount = $urandom; end
            2: begin
               total++;
               if (bus4.done !== 1'b1 || bus4.result !== 32'h0F00_0000) begin
                  bad++; $display("FAIL ign_dut4_done: got d=%b r=%h want 1 0f000000", bus4.done,
                                  bus4.result);
               end
               start = 1'b1; op = 3'd2; operand = 32'hFFFF_FFFF; amount = 32'd1;
            end
            3: begin
               start = 1'b0;
               total++;
               if (bus4.busy !== 1'b0) begin
                  bad++; $display("FAIL ign_done_cycle_dut4: got busy=%b want 0", bus4.busy);
               end
            end
            5: begin
               total++;
               if (bus1.done !== 1'b1 || bus1.result !== 32'h0F00_0000) begin
                  bad++; $display("FAIL ign_shift_start: got d=%b r=%h want 1 0f000000", bus1.done,
                                  bus1.result);
               end
               start = 1'b1; op = 3'd4; operand = 32'h1111_1111; amount = 32'd3;
            end
            6: begin
               start = 1'b0;
               total++;
               if (bus1.busy !== 1'b0 || bus1.result !== 32'h0F00_0000) begin
                  bad++; $display("FAIL ign_done_cycle: got b=%b r=%h want 0 0f000000", bus1.busy,
                                  bus1.result);
               end
            end
            default: ;
         endcase
      end
      // dut4 took the last pulse while idle; let it drain.
      w = 0;
      while (bus4.busy && w < 50) begin @(negedge clk); w++; end
      do_op(3'd3, 32'h0000_00FF, 32'd8, r1, i1, l1, b1, r4, i4, l4);
      total++;
      if (r1 !== 32'hFF00_0000 || r4 !== 32'hFF00_0000) begin
         bad++; $display("FAIL ign_next_accept: got %h/%h want ff000000", r1, r4);
      end
   endtask

   task automatic test_clear_mid();
      logic [W-1:0] r1, r4;
      logic i1, i4;
      int l1, b1, l4;
      @(negedge clk);
      start = 1'b1; op = 3'd0; operand = 32'hA5A5_A5A5; amount = 32'd20;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      total++;
      if (bus1.busy !== 1'b1) begin bad++; $display("FAIL clr_pre_busy: got %b want 1", bus1.busy); end
      clear = 1'b0;
      #1;
      total++;
      if (bus1.result !== 32'h0 || {bus1.busy, bus1.done, bus1.illegal} !== 3'b000 ||
          st1 !== ST_IDLE || bus4.busy !== 1'b0) begin
         bad++; $display("FAIL clr_immediate: got r=%h flags=%b st=%0d b4=%b want 0 000 0 0",
                         bus1.result, {bus1.busy, bus1.done, bus1.illegal}, st1, bus4.busy);
      end
      repeat (2) begin
         @(negedge clk);
         total++;
         if (bus1.done !== 1'b0 || bus4.done !== 1'b0) begin
            bad++; $display("FAIL clr_no_done: got %b/%b want 0/0", bus1.done, bus4.done);
         end
      end
      clear = 1'b1;
      do_op(3'd0, 32'hF000_0002, 32'd2, r1, i1, l1, b1, r4, i4, l4);
      total++;
      if (r1 !== 32'h3C00_0000 || r4 !== 32'h3C00_0000 || l1 !== 3 || l4 !== 2) begin
         bad++; $display("FAIL clr_after: got %h/%h lat %0d/%0d want 3c000000 lat 3/2", r1, r4, l1, l4);
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_ignore_start();
      test_clear_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
